// File: rtl/arb_pkg.sv
// Shared definitions for the one-hot select producers and their mux/demux consumers.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int DEFAULT_NUM_REQ = 4;
    localparam int MAX_REQ         = 32;

    // Callers size-cast the result down to their own select width.
    function automatic logic [MAX_REQ-1:0] onehot_from_idx(input int unsigned idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority search: first unmasked request at or above ptr, wrapping modulo NUM_REQ.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_REQ-1:0] cand;
    logic [IDX_W:0]     pos_sum;
    logic [IDX_W-1:0]   pos;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            assign cand[gi] = req[gi] & ~mask[gi];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest hit to ptr is written last.
    always_comb begin
        found   = 1'b0;
        idx     = '0;
        pos_sum = '0;
        pos     = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos_sum = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (pos_sum >= (IDX_W + 1)'(NUM_REQ)) begin
                pos_sum = pos_sum - (IDX_W + 1)'(NUM_REQ);
            end
            pos = pos_sum[IDX_W-1:0];
            if (cand[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter producing a registered one-hot grant held until the owner releases.
module rr_onehot_arbiter
    import arb_pkg::*;
#(
    parameter  int NUM_REQ = DEFAULT_NUM_REQ,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               ack_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic               gnt_vld_o,
    output logic [IDX_W-1:0]   gnt_idx_o
);

    arb_state_t         state_reg, state_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [NUM_REQ-1:0] gnt_reg, gnt_next;
    logic               vld_reg, vld_next;

    logic [NUM_REQ-1:0] owner_mask;
    logic               hand_over;
    logic [IDX_W-1:0]   ptr_after;
    logic [IDX_W-1:0]   pick_ptr;
    logic [NUM_REQ-1:0] pick_mask;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;

    assign owner_mask = NUM_REQ'(onehot_from_idx(int'(idx_reg)));
    assign hand_over  = (state_reg == BUSY) && (ack_i || ((req_i & owner_mask) == '0));
    assign ptr_after  = (idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : idx_reg + 1'b1;

    // On release the search already starts past the owner with its bit hidden,
    // so a handover never lands back on the releasing requester.
    assign pick_ptr  = hand_over ? ptr_after : ptr_reg;
    assign pick_mask = hand_over ? owner_mask : '0;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req_i),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign pick_onehot = NUM_REQ'(onehot_from_idx(int'(pick_idx)));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            idx_reg   <= '0;
            gnt_reg   <= '0;
            vld_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            idx_reg   <= idx_next;
            gnt_reg   <= gnt_next;
            vld_reg   <= vld_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        idx_next   = idx_reg;
        gnt_next   = gnt_reg;
        vld_next   = vld_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    state_next = BUSY;
                    idx_next   = pick_idx;
                    gnt_next   = pick_onehot;
                    vld_next   = 1'b1;
                end
            end
            BUSY: begin
                if (hand_over) begin
                    ptr_next = ptr_after;
                    if (pick_found) begin
                        idx_next = pick_idx;
                        gnt_next = pick_onehot;
                        vld_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                        gnt_next   = '0;
                        vld_next   = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign gnt_o     = gnt_reg;
    assign gnt_vld_o = vld_reg;
    assign gnt_idx_o = idx_reg;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed vector table plus randomized traffic against an ownership-level reference model.
module tb_rr_onehot_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req_i = '0;
    logic          ack_i = 1'b0;
    logic [N-1:0]  gnt_o;
    logic          gnt_vld_o;
    logic [IW-1:0] gnt_idx_o;

    always #5 clk = ~clk;

    rr_onehot_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_i     (req_i),
        .ack_i     (ack_i),
        .gnt_o     (gnt_o),
        .gnt_vld_o (gnt_vld_o),
        .gnt_idx_o (gnt_idx_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the grant, where the search starts, last granted index.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_last  = 0;

    function automatic int rr_find(input logic [N-1:0] r, input int start, input int excl);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (start + k) % N;
            if (i != excl && r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rst, input logic [N-1:0] q, input logic a);
        int p;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_last  = 0;
        end else if (m_owner < 0) begin
            p = rr_find(q, m_ptr, -1);
            if (p >= 0) begin
                m_owner = p;
                m_last  = p;
            end
        end else if (a || !q[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            p       = rr_find(q, m_ptr, m_owner);
            m_owner = p;
            if (p >= 0) m_last = p;
        end
    endtask

    task automatic drive_cycle(input logic rst, input logic [N-1:0] q, input logic a);
        @(negedge clk);
        reset = rst;
        req_i = q;
        ack_i = a;
        @(posedge clk);
        model_step(rst, q, a);
        #1;
    endtask

    typedef struct {
        logic          rst;
        logic [N-1:0]  req;
        logic          ack;
        logic [N-1:0]  gnt;
        logic [IW-1:0] idx;
        logic          vld;
    } vec_t;

    localparam int NVEC = 23;
    vec_t tbl [NVEC];

    initial begin
        logic [N-1:0]  q;
        logic          a;
        logic          r;
        logic [N-1:0]  exp_gnt;

        // reset with all requests high, then fair rotation with periodic ack
        tbl[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
        tbl[3]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
        tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
        tbl[5]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1};
        tbl[7]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1};
        tbl[8]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1};
        // owner 0 withdraws, 2 takes over and is not pre-empted by 3
        tbl[9]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
        tbl[10] = '{1'b0, 4'b1100, 1'b0, 4'b0100, 2'd2, 1'b1};
        tbl[11] = '{1'b0, 4'b1100, 1'b0, 4'b0100, 2'd2, 1'b1};
        tbl[12] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};
        // wrap-around release from owner 3
        tbl[13] = '{1'b0, 4'b1001, 1'b1, 4'b0001, 2'd0, 1'b1};
        tbl[14] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
        // single requester: masked for one cycle after ack, then regains
        tbl[15] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
        tbl[16] = '{1'b0, 4'b0010, 1'b1, 4'b0000, 2'd1, 1'b0};
        tbl[17] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1};
        // ack while idle does nothing
        tbl[18] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0};
        tbl[19] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd1, 1'b0};
        // reset mid-grant restores ptr=0
        tbl[20] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1};
        tbl[21] = '{1'b1, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0};
        tbl[22] = '{1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1};

        for (int v = 0; v < NVEC; v++) begin
            drive_cycle(tbl[v].rst, tbl[v].req, tbl[v].ack);
            $display("vec %0d rst=%b req=%b ack=%b -> gnt=%b idx=%0d vld=%b",
                     v, tbl[v].rst, tbl[v].req, tbl[v].ack, gnt_o, gnt_idx_o, gnt_vld_o);
            check("vec_gnt", 32'(gnt_o), 32'(tbl[v].gnt));
            check("vec_idx", 32'(gnt_idx_o), 32'(tbl[v].idx));
            check("vec_vld", 32'(gnt_vld_o), 32'(tbl[v].vld));
        end

        // randomized traffic starting from a clean reset
        q = '0;
        drive_cycle(1'b1, q, 1'b0);
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) q = N'($urandom);
            a = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 63) == 0);
            drive_cycle(r, q, a);
            exp_gnt = (m_owner >= 0) ? N'(1) << m_owner : '0;
            $display("rnd %0d rst=%b req=%b ack=%b -> gnt=%b idx=%0d vld=%b",
                     c, r, q, a, gnt_o, gnt_idx_o, gnt_vld_o);
            check("rnd_gnt", 32'(gnt_o), 32'(exp_gnt));
            check("rnd_vld", 32'(gnt_vld_o), 32'(m_owner >= 0));
            check("rnd_idx", 32'(gnt_idx_o), 32'(m_last));
            check("rnd_onehot0", 32'($onehot0(gnt_o)), 32'(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
